// File: rtl/btn_cmd_conditioner.sv
// Push-button conditioner: per-button two-flop synchroniser and debouncer,
// run/halt rise pulses, and a four-phase step_cycle/step_ack handshake.
module btn_cmd_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned DROP_W          = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:1]        btn_raw,
    input  logic              step_ack,
    output logic [3:1]        btn_level,
    output logic              dbg_run_core,
    output logic              dbg_halt_core,
    output logic              step_cycle,
    output logic              step_busy,
    output logic [DROP_W-1:0] step_drops
);

    localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_REL  = 2'd2
    } step_state_t;

    logic [3:1]       r_sync1;
    logic [3:1]       r_sync2;
    logic [3:1]       r_level;
    logic [CNT_W-1:0] r_cnt [1:3];
    logic             r_run;
    logic             r_halt;
    logic             r_step_cycle;
    logic             r_step_busy;
    logic [DROP_W-1:0] r_drops;
    step_state_t      r_state;

    logic [CNT_W-1:0] w_cnt_nxt [1:3];
    logic [3:1]       w_flip;
    logic [3:1]       w_rise;
    logic             w_drop;
    step_state_t      w_state_nxt;

    // Two-flop synchroniser for the asynchronous button inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 3'b000;
            r_sync2 <= 3'b000;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce decision: count consecutive mismatching cycles, flip on the last one
    always_comb begin
        for (int i = 1; i <= 3; i++) begin
            w_cnt_nxt[i] = '0;
            w_flip[i]    = 1'b0;
            if (r_sync2[i] == r_level[i]) begin
                w_cnt_nxt[i] = '0;
                w_flip[i]    = 1'b0;
            end else if (r_cnt[i] == CNT_LAST) begin
                w_cnt_nxt[i] = '0;
                w_flip[i]    = 1'b1;
            end else begin
                w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
                w_flip[i]    = 1'b0;
            end
        end
    end

    // A flip toward the synchronised value 1 is a press; releases raise no event
    assign w_rise = w_flip & r_sync2;
    assign w_drop = w_rise[3] & (r_state != ST_IDLE);

    // Debounce counters and accepted levels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= 3'b000;
            for (int i = 1; i <= 3; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_level <= r_level ^ w_flip;
            for (int i = 1; i <= 3; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

    // Run/halt pulses coincide with the flip; halt wins a same-edge tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run  <= 1'b0;
            r_halt <= 1'b0;
        end else begin
            r_run  <= w_rise[1] & ~w_rise[2];
            r_halt <= w_rise[2];
        end
    end

    // Step handshake next-state logic; no timeout, only reset escapes
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_rise[3]) begin
                    w_state_nxt = ST_REQ;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (step_ack) begin
                    w_state_nxt = ST_REL;
                end else begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REL: begin
                if (!step_ack) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_REL;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Step state plus registered copies of its decoded outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_step_cycle <= 1'b0;
            r_step_busy  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_step_cycle <= (w_state_nxt == ST_REQ);
            r_step_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    // Saturating count of presses that arrive while a step is in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drops <= '0;
        end else if (w_drop && (r_drops != {DROP_W{1'b1}})) begin
            r_drops <= r_drops + DROP_W'(1);
        end else begin
            r_drops <= r_drops;
        end
    end

    assign btn_level     = r_level;
    assign dbg_run_core  = r_run;
    assign dbg_halt_core = r_halt;
    assign step_cycle    = r_step_cycle;
    assign step_busy     = r_step_busy;
    assign step_drops    = r_drops;

endmodule

// File: tb/tb_btn_cmd_conditioner.sv
// Bench for btn_cmd_conditioner: directed scenarios with literal expectations,
// then randomized buttons/ack, all compared every cycle to a behavioural model.
module tb_btn_cmd_conditioner;

    localparam int DC = 4;
    localparam int DW = 2;
    localparam int DROP_MAX = (1 << DW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [3:1]    btn_raw = 3'b000;
    logic          step_ack = 1'b0;
    logic [3:1]    btn_level;
    logic          dbg_run_core;
    logic          dbg_halt_core;
    logic          step_cycle;
    logic          step_busy;
    logic [DW-1:0] step_drops;

    int checks = 0;
    int errors = 0;
    int run_cnt = 0;
    int halt_cnt = 0;

    // Model state: raw samples per edge (newest first), accepted levels, outputs
    bit [3:1] q[$];
    bit [3:1] m_level;
    bit       m_run, m_halt, m_req, m_busy;
    int       m_drops;

    btn_cmd_conditioner #(.DEBOUNCE_CYCLES(DC), .DROP_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .step_ack(step_ack),
        .btn_level(btn_level), .dbg_run_core(dbg_run_core),
        .dbg_halt_core(dbg_halt_core), .step_cycle(step_cycle),
        .step_busy(step_busy), .step_drops(step_drops)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < DC + 2; i++) q.push_back(3'b000);
        m_level = 3'b000;
        m_run = 1'b0; m_halt = 1'b0; m_req = 1'b0; m_busy = 1'b0;
        m_drops = 0;
    endtask

    // A level changes once the value seen after the 2-cycle synchroniser has
    // disagreed with it for DC consecutive edges.
    task automatic model_step(input bit [3:1] raw, input bit ack);
        bit [3:1] rise;
        bit       all_diff;
        q.push_front(raw);
        void'(q.pop_back());
        rise = 3'b000;
        for (int b = 1; b <= 3; b++) begin
            all_diff = 1'b1;
            for (int k = 2; k < DC + 2; k++) if (q[k][b] == m_level[b]) all_diff = 1'b0;
            if (all_diff) begin
                m_level[b] = ~m_level[b];
                if (m_level[b]) rise[b] = 1'b1;
            end
        end
        m_halt = rise[2];
        m_run  = rise[1] & ~rise[2];
        if (rise[3] && m_busy) m_drops = (m_drops == DROP_MAX) ? DROP_MAX : m_drops + 1;
        if (!m_busy) begin
            if (rise[3]) begin m_req = 1'b1; m_busy = 1'b1; end
        end else if (m_req) begin
            if (ack) m_req = 1'b0;
        end else if (!ack) begin
            m_busy = 1'b0;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step(btn_raw, step_ack);
        end
    end

    // Per-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            chk("cycle_outputs",
                {23'd0, btn_level, dbg_run_core, dbg_halt_core, step_cycle, step_busy, step_drops},
                {23'd0, m_level, m_run, m_halt, m_req, m_busy, DW'(m_drops)});
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (dbg_run_core === 1'b1) run_cnt++;
            if (dbg_halt_core === 1'b1) halt_cnt++;
        end
    end

    task automatic wait_to_flip();
        repeat (5) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int r0, h0;
        repeat (3) @(negedge clk);
        chk("reset_state",
            {23'd0, btn_level, dbg_run_core, dbg_halt_core, step_cycle, step_busy, step_drops}, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Clean press of button 1
        btn_raw[1] = 1'b1;
        wait_to_flip();
        chk("b1_before_flip", {31'd0, btn_level[1]}, 32'd0);
        @(negedge clk);
        chk("b1_level", {31'd0, btn_level[1]}, 32'd1);
        chk("b1_run_pulse", {31'd0, dbg_run_core}, 32'd1);
        chk("b1_no_halt", {31'd0, dbg_halt_core}, 32'd0);
        @(negedge clk);
        chk("b1_run_cleared", {31'd0, dbg_run_core}, 32'd0);
        r0 = run_cnt;
        btn_raw[1] = 1'b0;
        repeat (8) @(negedge clk);
        chk("b1_release_level", {31'd0, btn_level[1]}, 32'd0);
        chk("b1_release_no_pulse", run_cnt - r0, 32'd0);

        // Bounce on button 2: runs of 3 cycles never reach DC
        h0 = halt_cnt;
        for (int t = 0; t < 10; t++) begin
            btn_raw[2] = (t % 2 == 0);
            repeat (3) @(negedge clk);
        end
        chk("bounce_no_pulse", halt_cnt - h0, 32'd0);
        chk("bounce_level", {31'd0, btn_level[2]}, 32'd0);
        btn_raw[2] = 1'b1;
        wait_to_flip();
        chk("bounce_before_flip", {31'd0, dbg_halt_core}, 32'd0);
        @(negedge clk);
        chk("bounce_halt_pulse", {31'd0, dbg_halt_core}, 32'd1);
        chk("bounce_one_pulse", halt_cnt - h0, 32'd1);
        btn_raw[2] = 1'b0;
        repeat (8) @(negedge clk);
        chk("bounce_release", halt_cnt - h0, 32'd1);

        // Simultaneous press of buttons 1 and 2
        r0 = run_cnt; h0 = halt_cnt;
        btn_raw[2:1] = 2'b11;
        wait_to_flip();
        @(negedge clk);
        chk("simul_pulses", {30'd0, dbg_run_core, dbg_halt_core}, 32'd1);
        @(negedge clk);
        chk("simul_run_count", run_cnt - r0, 32'd0);
        chk("simul_halt_count", halt_cnt - h0, 32'd1);
        btn_raw[2:1] = 2'b00;
        repeat (8) @(negedge clk);

        // Step handshake, 3-cycle responder delays
        btn_raw[3] = 1'b1;
        wait_to_flip();
        chk("step_before_flip", {31'd0, step_cycle}, 32'd0);
        @(negedge clk);
        chk("step_rise", {29'd0, btn_level[3], step_cycle, step_busy}, 32'd7);
        repeat (3) @(negedge clk);
        step_ack = 1'b1;
        @(negedge clk);
        chk("step_req_to_rel", {30'd0, step_cycle, step_busy}, 32'd1);
        repeat (3) @(negedge clk);
        step_ack = 1'b0;
        @(negedge clk);
        chk("step_done", {30'd0, step_cycle, step_busy}, 32'd0);
        chk("step_no_drops", {30'd0, step_drops}, 32'd0);
        btn_raw[3] = 1'b0;
        repeat (8) @(negedge clk);

        // Drops while held in REQ, saturating at 3
        btn_raw[3] = 1'b1;
        wait_to_flip();
        @(negedge clk);
        chk("drop_in_req", {31'd0, step_cycle}, 32'd1);
        for (int p = 1; p <= 5; p++) begin
            btn_raw[3] = 1'b0;
            repeat (8) @(negedge clk);
            btn_raw[3] = 1'b1;
            wait_to_flip();
            @(negedge clk);
            chk("drop_count", {30'd0, step_drops}, (p < 3) ? p : 3);
            chk("drop_still_req", {31'd0, step_cycle}, 32'd1);
        end

        // Reset mid-step with button 3 held
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_step", {29'd0, step_cycle, step_busy, step_drops}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_to_flip();
        chk("rst_before_rise", {31'd0, step_cycle}, 32'd0);
        @(negedge clk);
        chk("rst_new_rise", {31'd0, step_cycle}, 32'd1);
        step_ack = 1'b1;
        repeat (3) @(negedge clk);

        // Randomized buttons and ack, with one reset in the middle
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            for (int b = 1; b <= 3; b++)
                if ($urandom_range(0, 5) == 0) btn_raw[b] = ~btn_raw[b];
            if ($urandom_range(0, 3) == 0) step_ack = ~step_ack;
            if (c == 2000) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
